// File: rtl/pe_ws_dbuf_if.sv
// Port bundle for one weight-stationary PE: weight chain, activation pass-through,
// partial-sum flow, clear and gating statistics. master drives a PE, slave is the PE.
interface pe_ws_dbuf_if #(
    parameter int WIDTH_A   = 8,
    parameter int WIDTH_W   = 8,
    parameter int WIDTH_MAC = 32,
    parameter int CNT_W     = 16
);
    logic                 clear;
    logic [WIDTH_W-1:0]   w_in;
    logic                 w_load;
    logic [WIDTH_W-1:0]   w_out;
    logic [WIDTH_A-1:0]   act_in;
    logic                 act_valid;
    logic                 swap_in;
    logic [WIDTH_A-1:0]   act_out;
    logic                 act_valid_out;
    logic                 swap_out;
    logic [WIDTH_MAC-1:0] psum_in;
    logic [WIDTH_MAC-1:0] psum_out;
    logic                 psum_valid_out;
    logic [CNT_W-1:0]     zero_cnt;

    modport master (
        output clear, w_in, w_load, act_in, act_valid, swap_in, psum_in,
        input  w_out, act_out, act_valid_out, swap_out, psum_out, psum_valid_out, zero_cnt
    );

    modport slave (
        input  clear, w_in, w_load, act_in, act_valid, swap_in, psum_in,
        output w_out, act_out, act_valid_out, swap_out, psum_out, psum_valid_out, zero_cnt
    );
endinterface

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary PE with a double-buffered weight (shadow preloaded via a vertical
// shift chain, swapped in by a token riding the activation), pipelined MAC and zero gating.
module pe_ws_dbuf #(
    parameter int WIDTH_A   = 8,
    parameter int WIDTH_W   = 8,
    parameter int WIDTH_MAC = 32,
    parameter int STAGE     = 1,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 0,
    parameter int ZERO_GATE = 1,
    parameter int CNT_W     = 16
) (
    input logic          clk,
    input logic          rst_n,
    pe_ws_dbuf_if.slave  bus
);

    localparam int PD = (STAGE > 0) ? STAGE : 1;

    function automatic logic [WIDTH_MAC-1:0] mul_ext(input logic [WIDTH_A-1:0] a,
                                                     input logic [WIDTH_W-1:0] w);
        logic signed [WIDTH_MAC-1:0] a_x;
        logic signed [WIDTH_MAC-1:0] w_x;
        logic signed [WIDTH_MAC-1:0] p;
        a_x = {{(WIDTH_MAC-WIDTH_A){(SIGNED != 0) && a[WIDTH_A-1]}}, a};
        w_x = {{(WIDTH_MAC-WIDTH_W){(SIGNED != 0) && w[WIDTH_W-1]}}, w};
        // Low WIDTH_MAC bits of the extended product are exact since WIDTH_MAC >= WIDTH_A+WIDTH_W.
        p = a_x * w_x;
        return p;
    endfunction

    function automatic logic [WIDTH_MAC-1:0] acc_add(input logic [WIDTH_MAC-1:0] a,
                                                     input logic [WIDTH_MAC-1:0] b);
        logic [WIDTH_MAC:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SATURATE == 0) begin
            return s[WIDTH_MAC-1:0];
        end
        if (SIGNED != 0) begin
            if ((a[WIDTH_MAC-1] == b[WIDTH_MAC-1]) && (s[WIDTH_MAC-1] != a[WIDTH_MAC-1])) begin
                return a[WIDTH_MAC-1] ? {1'b1, {(WIDTH_MAC-1){1'b0}}}
                                      : {1'b0, {(WIDTH_MAC-1){1'b1}}};
            end
            return s[WIDTH_MAC-1:0];
        end
        return s[WIDTH_MAC] ? {WIDTH_MAC{1'b1}} : s[WIDTH_MAC-1:0];
    endfunction

    logic [WIDTH_W-1:0]   shadow_q, shadow_d;
    logic [WIDTH_W-1:0]   active_q, active_d;
    logic [WIDTH_W-1:0]   w_eff;
    logic [WIDTH_A-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH_W-1:0]   mul_w_q, mul_w_d;
    logic [WIDTH_A-1:0]   act_q, act_d;
    logic                 act_vld_q, act_vld_d;
    logic                 swap_q, swap_d;
    logic [WIDTH_MAC-1:0] psum_q, psum_d;
    logic                 psum_vld_q, psum_vld_d;
    logic [CNT_W-1:0]     zero_cnt_q, zero_cnt_d;
    logic                 gate;
    logic                 mul_en;
    logic [WIDTH_MAC-1:0] prod_p0;
    logic [WIDTH_MAC-1:0] prod_end;
    logic [WIDTH_MAC-1:0] psum_end;
    logic                 vld_end;

    always_comb begin
        w_eff   = bus.swap_in ? shadow_q : active_q;
        gate    = (ZERO_GATE != 0) && bus.act_valid &&
                  ((bus.act_in == '0) || (w_eff == '0));
        mul_en  = bus.act_valid && !gate;
        // Operand registers only follow the inputs on real multiplies, keeping the array quiet.
        mul_a_d = mul_en ? bus.act_in : mul_a_q;
        mul_w_d = mul_en ? w_eff : mul_w_q;
        prod_p0 = mul_en ? mul_ext(mul_a_d, mul_w_d) : '0;

        shadow_d   = bus.w_load ? bus.w_in : shadow_q;
        active_d   = bus.swap_in ? shadow_q : active_q;
        act_d      = bus.act_in;
        act_vld_d  = bus.act_valid;
        swap_d     = bus.swap_in;
        psum_vld_d = vld_end;
        psum_d     = vld_end ? acc_add(psum_end, prod_end) : psum_q;
        zero_cnt_d = (gate && (zero_cnt_q != {CNT_W{1'b1}})) ? zero_cnt_q + CNT_W'(1) : zero_cnt_q;

        if (bus.clear) begin
            shadow_d   = '0;
            active_d   = '0;
            mul_a_d    = '0;
            mul_w_d    = '0;
            act_d      = '0;
            act_vld_d  = 1'b0;
            swap_d     = 1'b0;
            psum_vld_d = 1'b0;
            psum_d     = '0;
            zero_cnt_d = '0;
        end
    end

    // Product pipe: STAGE registers between the multiplier and the accumulate.
    generate
        if (STAGE > 0) begin : g_pipe
            logic [WIDTH_MAC-1:0] prod_pipe_q [PD];
            logic [WIDTH_MAC-1:0] prod_pipe_d [PD];
            logic [WIDTH_MAC-1:0] psum_pipe_q [PD];
            logic [WIDTH_MAC-1:0] psum_pipe_d [PD];
            logic [PD-1:0]        vld_pipe_q, vld_pipe_d;

            always_comb begin
                prod_pipe_d[0] = prod_p0;
                psum_pipe_d[0] = bus.psum_in;
                vld_pipe_d[0]  = bus.act_valid;
                for (int i = 1; i < PD; i++) begin
                    prod_pipe_d[i] = prod_pipe_q[i-1];
                    psum_pipe_d[i] = psum_pipe_q[i-1];
                    vld_pipe_d[i]  = vld_pipe_q[i-1];
                end
                if (bus.clear) begin
                    for (int i = 0; i < PD; i++) begin
                        prod_pipe_d[i] = '0;
                        psum_pipe_d[i] = '0;
                    end
                    vld_pipe_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PD; i++) begin
                        prod_pipe_q[i] <= '0;
                        psum_pipe_q[i] <= '0;
                    end
                    vld_pipe_q <= '0;
                end else begin
                    prod_pipe_q <= prod_pipe_d;
                    psum_pipe_q <= psum_pipe_d;
                    vld_pipe_q  <= vld_pipe_d;
                end
            end

            assign prod_end = prod_pipe_q[PD-1];
            assign psum_end = psum_pipe_q[PD-1];
            assign vld_end  = vld_pipe_q[PD-1];
        end else begin : g_nopipe
            assign prod_end = prod_p0;
            assign psum_end = bus.psum_in;
            assign vld_end  = bus.act_valid;
        end
    endgenerate

    // Accumulate stage and horizontal pass-through registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            active_q   <= '0;
            mul_a_q    <= '0;
            mul_w_q    <= '0;
            act_q      <= '0;
            act_vld_q  <= 1'b0;
            swap_q     <= 1'b0;
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
            zero_cnt_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            mul_a_q    <= mul_a_d;
            mul_w_q    <= mul_w_d;
            act_q      <= act_d;
            act_vld_q  <= act_vld_d;
            swap_q     <= swap_d;
            psum_q     <= psum_d;
            psum_vld_q <= psum_vld_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign bus.w_out          = shadow_q;
    assign bus.act_out        = act_q;
    assign bus.act_valid_out  = act_vld_q;
    assign bus.swap_out       = swap_q;
    assign bus.psum_out       = psum_q;
    assign bus.psum_valid_out = psum_vld_q;
    assign bus.zero_cnt       = zero_cnt_q;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Scoreboard bench for pe_ws_dbuf: a default PE plus two 16-bit PEs (saturating, STAGE=2;
// wrapping, STAGE=0) sharing stimulus. Expected psums carry the cycle they must appear in.
module tb_pe_ws_dbuf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_ws_dbuf_if #(.WIDTH_A(8), .WIDTH_W(8), .WIDTH_MAC(32), .CNT_W(16)) bm ();
    pe_ws_dbuf_if #(.WIDTH_A(8), .WIDTH_W(8), .WIDTH_MAC(16), .CNT_W(2))  bs ();
    pe_ws_dbuf_if #(.WIDTH_A(8), .WIDTH_W(8), .WIDTH_MAC(16), .CNT_W(2))  bw ();

    pe_ws_dbuf #(.WIDTH_A(8), .WIDTH_W(8), .WIDTH_MAC(32), .STAGE(1), .SIGNED(1),
                 .SATURATE(0), .ZERO_GATE(1), .CNT_W(16))
        u_main (.clk(clk), .rst_n(rst_n), .bus(bm));
    pe_ws_dbuf #(.WIDTH_A(8), .WIDTH_W(8), .WIDTH_MAC(16), .STAGE(2), .SIGNED(1),
                 .SATURATE(1), .ZERO_GATE(1), .CNT_W(2))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(bs));
    pe_ws_dbuf #(.WIDTH_A(8), .WIDTH_W(8), .WIDTH_MAC(16), .STAGE(0), .SIGNED(1),
                 .SATURATE(0), .ZERO_GATE(1), .CNT_W(2))
        u_wrap (.clk(clk), .rst_n(rst_n), .bus(bw));

    typedef struct {
        logic [31:0] v;
        int          due;
    } exp_t;

    exp_t q_main[$];
    exp_t q_sat[$];
    exp_t q_wrap[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic m_drive(input logic v, input logic [7:0] a, input logic sw,
                           input logic [31:0] ps, input logic wl, input logic [7:0] wi);
        bm.act_valid = v;
        bm.act_in    = a;
        bm.swap_in   = sw;
        bm.psum_in   = ps;
        bm.w_load    = wl;
        bm.w_in      = wi;
    endtask

    task automatic m_exp(input logic [31:0] v);
        q_main.push_back('{v, cyc + 2});
    endtask

    task automatic s_drive(input logic v, input logic [7:0] a, input logic sw,
                           input logic [15:0] ps, input logic wl, input logic [7:0] wi);
        bs.act_valid = v;  bw.act_valid = v;
        bs.act_in    = a;  bw.act_in    = a;
        bs.swap_in   = sw; bw.swap_in   = sw;
        bs.psum_in   = ps; bw.psum_in   = ps;
        bs.w_load    = wl; bw.w_load    = wl;
        bs.w_in      = wi; bw.w_in      = wi;
    endtask

    task automatic s_exp(input logic [15:0] vs, input logic [15:0] vw);
        q_sat.push_back('{32'(vs), cyc + 3});
        q_wrap.push_back('{32'(vw), cyc + 1});
    endtask

    // Monitor: pop and compare whenever a PE strobes psum_valid_out.
    always @(negedge clk) begin
        exp_t e;
        if (bm.psum_valid_out === 1'b1) begin
            if (q_main.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL main_unexpected_valid: got psum 0x%0h, required no strobe", bm.psum_out);
            end else begin
                e = q_main.pop_front();
                check("main_psum", bm.psum_out, e.v);
                check("main_latency", 32'(cyc), 32'(e.due));
            end
        end
        if (bs.psum_valid_out === 1'b1) begin
            if (q_sat.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sat_unexpected_valid: got psum 0x%0h, required no strobe", bs.psum_out);
            end else begin
                e = q_sat.pop_front();
                check("sat_psum", 32'(bs.psum_out), e.v);
                check("sat_latency", 32'(cyc), 32'(e.due));
            end
        end
        if (bw.psum_valid_out === 1'b1) begin
            if (q_wrap.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL wrap_unexpected_valid: got psum 0x%0h, required no strobe", bw.psum_out);
            end else begin
                e = q_wrap.pop_front();
                check("wrap_psum", 32'(bw.psum_out), e.v);
                check("wrap_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required $finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bm.clear = 1'b0; bs.clear = 1'b0; bw.clear = 1'b0;
        m_drive(0, 0, 0, 0, 0, 0);
        s_drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_psum_out", bm.psum_out, 32'd0);
        check("rst_zero_cnt", 32'(bm.zero_cnt), 32'd0);
        check("rst_w_out", 32'(bm.w_out), 32'd0);
        check("rst_act_out", 32'(bm.act_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load 5 into shadow, then swap it in with act=-3, psum=100 -> 85.
        m_drive(0, 0, 0, 0, 1, 8'd5);
        tick();
        check("load_w_out", 32'(bm.w_out), 32'd5);
        m_drive(1, 8'hFD, 1, 32'd100, 0, 0);
        m_exp(32'd85);
        tick();
        m_drive(0, 0, 0, 0, 0, 0);
        check("pass_act_out", 32'(bm.act_out), 32'h0000_00FD);
        check("pass_swap_out", 32'(bm.swap_out), 32'd1);
        check("pass_act_valid_out", 32'(bm.act_valid_out), 32'd1);
        repeat (2) tick();

        // Double buffer: active=5, shadow=7; third op swaps while shadow loads 9.
        m_drive(0, 0, 0, 0, 1, 8'd7);
        tick();
        m_drive(1, 8'd2, 0, 32'd0, 0, 0); m_exp(32'd10); tick();
        m_drive(1, 8'd2, 0, 32'd0, 0, 0); m_exp(32'd10); tick();
        m_drive(1, 8'd2, 1, 32'd0, 1, 8'd9); m_exp(32'd14); tick();
        m_drive(0, 0, 0, 0, 0, 0);
        check("dbuf_shadow_9", 32'(bm.w_out), 32'd9);
        m_drive(1, 8'd1, 0, 32'd0, 0, 0); m_exp(32'd7); tick();
        m_drive(1, 8'd1, 1, 32'd1000, 0, 0); m_exp(32'd1009); tick();
        m_drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Zero gating with w_eff=2; swap happens on an invalid cycle.
        m_drive(0, 0, 0, 0, 1, 8'd2); tick();
        m_drive(0, 0, 1, 0, 0, 0); tick();
        m_drive(0, 0, 0, 0, 0, 0);
        check("swap_no_valid_swap_out", 32'(bm.swap_out), 32'd1);
        check("swap_no_valid_act_valid_out", 32'(bm.act_valid_out), 32'd0);
        check("swap_no_valid_zero_cnt", 32'(bm.zero_cnt), 32'd0);
        tick();
        m_drive(1, 8'd0, 0, 32'd10, 0, 0); m_exp(32'd10); tick();
        check("gate_hold_mul_a", 32'(u_main.mul_a_q), 32'd1);
        check("gate_hold_mul_w", 32'(u_main.mul_w_q), 32'd9);
        m_drive(1, 8'd0, 0, 32'd20, 0, 0); m_exp(32'd20); tick();
        m_drive(1, 8'd3, 0, 32'd30, 0, 0); m_exp(32'd36); tick();
        check("gate_load_mul_a", 32'(u_main.mul_a_q), 32'd3);
        m_drive(1, 8'd0, 0, 32'd40, 0, 0); m_exp(32'd40); tick();
        check("gate_hold_mul_a2", 32'(u_main.mul_a_q), 32'd3);
        check("gate_hold_mul_w2", 32'(u_main.mul_w_q), 32'd2);
        m_drive(1, 8'd1, 0, 32'd50, 0, 0); m_exp(32'd52); tick();
        m_drive(0, 0, 0, 0, 0, 0);
        check("gate_zero_cnt", 32'(bm.zero_cnt), 32'd3);
        repeat (2) tick();
        check("gate_zero_cnt_idle", 32'(bm.zero_cnt), 32'd3);

        // Saturating vs wrapping 16-bit accumulate with w_eff=4.
        s_drive(0, 0, 0, 0, 1, 8'd4); tick();
        s_drive(1, 8'd4, 1, 16'h7FF8, 0, 0); s_exp(16'h7FFF, 16'h8008); tick();
        s_drive(1, 8'hFC, 0, 16'h8008, 0, 0); s_exp(16'h8000, 16'h7FF8); tick();
        s_drive(1, 8'hFD, 0, 16'd100, 0, 0); s_exp(16'd88, 16'd88); tick();

        // Two-bit gate counter saturates at 3, then clear wipes all state.
        repeat (5) begin
            s_drive(1, 8'd0, 0, 16'd7, 0, 0); s_exp(16'd7, 16'd7); tick();
        end
        s_drive(0, 0, 0, 0, 0, 0);
        check("cnt_sat_sat", 32'(bs.zero_cnt), 32'd3);
        check("cnt_sat_wrap", 32'(bw.zero_cnt), 32'd3);
        repeat (3) tick();
        bs.clear = 1'b1; bw.clear = 1'b1;
        tick();
        bs.clear = 1'b0; bw.clear = 1'b0;
        check("clr_zero_cnt", 32'(bs.zero_cnt), 32'd0);
        check("clr_shadow", 32'(bs.w_out), 32'd0);
        check("clr_psum_out", 32'(bs.psum_out), 32'd0);
        check("clr_wrap_psum_out", 32'(bw.psum_out), 32'd0);
        s_drive(1, 8'd5, 0, 16'd1, 0, 0); s_exp(16'd1, 16'd1); tick();
        s_drive(0, 0, 0, 0, 0, 0);
        check("clr_active_gated", 32'(bs.zero_cnt), 32'd1);
        repeat (4) tick();

        // Reset while a result is still in the pipe.
        m_drive(1, 8'd6, 0, 32'd5, 0, 0); tick();
        m_drive(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_psum_out", bm.psum_out, 32'd0);
        check("rst_mid_psum_valid", 32'(bm.psum_valid_out), 32'd0);
        check("rst_mid_act_out", 32'(bm.act_out), 32'd0);
        check("rst_mid_act_valid_out", 32'(bm.act_valid_out), 32'd0);
        check("rst_mid_w_out", 32'(bm.w_out), 32'd0);
        check("rst_mid_zero_cnt", 32'(bm.zero_cnt), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("rst_mid_no_valid", 32'(bm.psum_valid_out), 32'd0);
        end

        check("main_queue_empty", 32'(q_main.size()), 32'd0);
        check("sat_queue_empty", 32'(q_sat.size()), 32'd0);
        check("wrap_queue_empty", 32'(q_wrap.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_ws_dbuf.md
Name: pe_ws_dbuf

Overview:
- Next-generation weight-stationary processing element for the systolic array.
- Holds a double-buffered weight: a shadow register is preloaded through a vertical shift chain while the active weight keeps computing. A swap token travels with the activation wavefront, so the array changes weights without a bubble.
- Activations pass horizontally; partial sums flow vertically through a STAGE-deep multiply pipeline plus a registered accumulate.
- Optional zero gating, optional saturation, and a gated-operation counter for power statistics.

Parameters:
- WIDTH_A, 8: activation width.
- WIDTH_W, 8: weight width.
- WIDTH_MAC, 32: partial-sum width. Must satisfy WIDTH_MAC >= WIDTH_A+WIDTH_W.
- STAGE, 1: product pipeline registers, range 0..3.
- SIGNED, 1: 1 = two's-complement operands and psum; 0 = unsigned.
- SATURATE, 0: 1 = clamp the accumulate to the WIDTH_MAC range; 0 = wrap modulo 2^WIDTH_MAC.
- ZERO_GATE, 1: 1 = skip the multiply when either operand is 0.
- CNT_W, 16: width of the zero-gate counter.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- clear, in, 1: synchronous clear of all state.
- w_in, in, WIDTH_W: weight shift-chain input from the PE above.
- w_load, in, 1: shift-chain enable, broadcast to the whole column.
- w_out, out, WIDTH_W: shift-chain output to the PE below (equals shadow).
- act_in, in, WIDTH_A: activation from the left.
- act_valid, in, 1: act_in valid.
- swap_in, in, 1: weight-swap token aligned with act_in.
- act_out, out, WIDTH_A: registered act_in to the right.
- act_valid_out, out, 1: registered act_valid.
- swap_out, out, 1: registered swap_in.
- psum_in, in, WIDTH_MAC: partial sum from above.
- psum_out, out, WIDTH_MAC: partial sum downward.
- psum_valid_out, out, 1: psum_out valid strobe.
- zero_cnt, out, CNT_W: count of gated operations, saturating.

Behaviour:
- Reset (rst_n low, async) and clear (sync, highest priority after reset) both zero: shadow, active, all pipe stages, act_out, act_valid_out, swap_out, psum_out, psum_valid_out and zero_cnt. Reset mid-operation drops all in-flight data; there is no recovery of partial results.
- Weight chain:
  - When w_load = 1, shadow <= w_in; otherwise shadow holds.
  - w_out = shadow, so an N-deep column loads in N w_load cycles.
  - The first weight shifted in ends up in the bottom PE.
- Swap:
  - Effective weight w_eff = swap_in ? shadow : active. The activation arriving with the token already uses the new weight.
  - On swap_in = 1 (independent of act_valid), active <= shadow.
  - w_load and swap_in in the same cycle: the swap takes the pre-load shadow value, and shadow takes w_in.
  - swap_in with act_valid = 0 still swaps and still propagates to swap_out.
- Horizontal pass: act_out, act_valid_out and swap_out are registered copies of their inputs every cycle, with 1-cycle latency.
- MAC datapath:
  - Product = act_in × w_eff, width WIDTH_A+WIDTH_W.
  - The product is sign-extended (SIGNED = 1) or zero-extended to WIDTH_MAC.
  - The product, psum_in and act_valid enter a STAGE-deep shift pipe that advances every cycle.
  - Accumulate register: when the pipe-end valid = 1, psum_out <= psum_pipe + product_pipe; otherwise psum_out holds its last value.
  - psum_valid_out is a 1-cycle strobe.
  - Total latency from act_valid to psum_valid_out is STAGE+1 cycles. Throughput is one operation per cycle, back-to-back.
- Saturation:
  - SATURATE = 1, SIGNED = 1: clamp to [-2^(WIDTH_MAC-1), 2^(WIDTH_MAC-1)-1].
  - SATURATE = 1, SIGNED = 0: clamp to [0, 2^WIDTH_MAC-1].
  - SATURATE = 0: wrap.
- Zero gating (ZERO_GATE = 1):
  - If act_valid and (act_in == 0 or w_eff == 0), the multiplier input registers hold their previous values (no toggling) and a zero product is injected into the pipe.
  - psum passes through unchanged.
  - zero_cnt increments and sticks at 2^CNT_W-1.
  - With ZERO_GATE = 0, zero_cnt stays 0.
- Invalid cycles (act_valid = 0) never change psum_out or zero_cnt. The pipe still shifts, carrying valid = 0.

Test Plan:
- Reset mid-stream: assert rst_n low while psum_valid_out is pending -> all outputs 0 immediately; no psum_valid_out after release.
- Load and compute, STAGE = 1, SIGNED = 1:
  - Stimulus: w_load = 1 with w_in = 5 for 1 cycle; swap_in = 1 with act_in = -3, act_valid = 1, psum_in = 100.
  - Required: psum_out = 85 with psum_valid_out high exactly 2 cycles later; act_out = -3 and swap_out = 1 after 1 cycle.
- Double buffer:
  - Stimulus: active = 5; preload shadow = 7; stream act_in = 2 with psum_in = 0 for 3 cycles, swap_in on the 3rd.
  - Required: outputs 10, 10, 14. Simultaneous w_load (w_in = 9) with the swap leaves active = 7, shadow = 9.
- Saturation:
  - Stimulus: SATURATE = 1, WIDTH_MAC = 16, SIGNED = 1; psum_in = 32760, act_in = 4, w_eff = 4.
  - Required: psum_out = 32767. With SATURATE = 0: psum_out = -32760.
- Zero gating: 5 valid cycles with act_in = 0, 0, 3, 0, 1 and w_eff = 2 -> zero_cnt = 3; multiplier inputs unchanged on gated cycles; psum passes through.
- Counter saturation and clear: CNT_W = 2, 5 gated ops -> zero_cnt = 3; then clear -> zero_cnt, shadow, active and psum_out all 0 next cycle.
